awg_output_coupling: RTL

//  Output-side counterpart of the scope input coupling stage: conditions 2's complement

---
 rtl/awg_output_coupling_pkg.sv | 35 +++
 rtl/awg_output_coupling_if.sv | 30 +++
 rtl/awg_output_coupling_offset_slew.sv | 87 ++++++++
 rtl/awg_output_coupling.sv | 94 +++++++++
 4 files changed

// File: rtl/awg_output_coupling_pkg.sv
// Shared definitions for the AWG output coupling stage.
//   AWG_W / AWG_K / AWG_STEP : default sample width, DC estimator time constant
//                              (2^K samples) and offset slew limit in LSBs.
//   slew_state_e             : offset slew FSM encoding (SETTLED=0, RAMP=1).
//   sat_to_width()           : clamps a signed value to the range of a w-bit
//                              2's complement number (w <= 63).
package awg_output_coupling_pkg;

  localparam int AWG_W    = 24;
  localparam int AWG_K    = 8;
  localparam int AWG_STEP = 16;

  typedef enum logic {
    SETTLED = 1'b0,
    RAMP    = 1'b1
  } slew_state_e;

  // Callers sign-extend into 64 bits and truncate the result back with a
  // size cast, so one helper serves every width in the datapath.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/awg_output_coupling_if.sv
// Sample bus between the waveform synthesiser and the output coupling stage.
//   Input / Input_Valid : 2's complement sample and its qualifier
//   Offset              : target DC offset, 2's complement
//   Coupling            : 1 = AC, 0 = DC
//   Output / Output_Valid : conditioned, saturated sample and its qualifier
//   Settling            : high while the applied offset is still ramping
// master = sample source, slave = coupling stage.
interface awg_output_coupling_if
  import awg_output_coupling_pkg::*;
#(
  parameter int W = AWG_W
);
  logic signed [W-1:0] Input;
  logic                Input_Valid;
  logic signed [W-1:0] Offset;
  logic                Coupling;
  logic signed [W-1:0] Output;
  logic                Output_Valid;
  logic                Settling;

  modport master (
    output Input, Input_Valid, Offset, Coupling,
    input  Output, Output_Valid, Settling
  );

  modport slave (
    input  Input, Input_Valid, Offset, Coupling,
    output Output, Output_Valid, Settling
  );
endinterface

// File: rtl/awg_output_coupling_offset_slew.sv
// Applied-offset register with slew limiting.
//   Clk, nReset : clock, asynchronous active-low reset
//   target      : offset the ramp heads for (W bits, signed)
//   comp        : DC compensation added to A on a coupling change (W+1 bits)
//   comp_stb    : apply comp this cycle (only meaningful with advance)
//   advance     : a valid sample is being processed; nothing moves otherwise
//   a           : applied offset A (W+1 bits, signed, saturating)
//   settling    : registered, high while the FSM is in RAMP
module awg_output_coupling_offset_slew
  import awg_output_coupling_pkg::*;
#(
  parameter int W    = AWG_W,
  parameter int STEP = AWG_STEP
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic signed [W-1:0] target,
  input  logic signed [W:0]   comp,
  input  logic                comp_stb,
  input  logic                advance,
  output logic signed [W:0]   a,
  output logic                settling
);

  localparam logic signed [W+1:0] STEP_S = (W+2)'(STEP);

  slew_state_e         state_q, state_d;
  logic signed [W:0]   a_q, a_d;
  logic                settling_q;

  logic signed [W+1:0] a_comp_wide;
  logic signed [W:0]   a_base;
  logic signed [W+1:0] diff;
  logic signed [W:0]   a_step;

  always_comb begin
    // Compensation lands first; the slew step is then taken from there.
    a_comp_wide = (W+2)'(a_q) + (W+2)'(comp);
    a_base      = comp_stb ? (W+1)'(sat_to_width(64'(a_comp_wide), W + 1)) : a_q;

    diff = (W+2)'(target) - (W+2)'(a_base);
    if (diff > STEP_S) begin
      a_step = a_base + (W+1)'(STEP);
    end else if (diff < -STEP_S) begin
      a_step = a_base - (W+1)'(STEP);
    end else begin
      a_step = (W+1)'(target);
    end

    a_d     = a_q;
    state_d = state_q;
    if (advance) begin
      if (comp_stb) begin
        // A coupling change always lands in RAMP, even mid-ramp; the
        // following RAMP cycle retires it if A already sits on target.
        a_d     = a_step;
        state_d = RAMP;
      end else if (state_q == SETTLED) begin
        // Leaving SETTLED costs one sample with A held.
        if (a_q != (W+1)'(target)) begin
          state_d = RAMP;
        end
      end else begin
        a_d = a_step;
        if (a_step == (W+1)'(target)) begin
          state_d = SETTLED;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= SETTLED;
      a_q        <= '0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      settling_q <= (state_d == RAMP);
    end
  end

  assign a        = a_q;
  assign settling = settling_q;

endmodule

// File: rtl/awg_output_coupling.sv
// Output coupling stage between the waveform synthesiser and the DAC.
// Optional AC coupling subtracts a leaky-integrator DC estimate, then a
// slew-limited offset is added and the result saturated to W bits.
//   Clk, nReset : clock, asynchronous active-low reset
//   bus         : awg_output_coupling_if slave (Input/Input_Valid, Offset,
//                 Coupling in; Output/Output_Valid, Settling out)
// Latency is two clocks from a valid Input to its Output.
module awg_output_coupling
  import awg_output_coupling_pkg::*;
#(
  parameter int W    = AWG_W,
  parameter int K    = AWG_K,
  parameter int STEP = AWG_STEP
) (
  input  logic                  Clk,
  input  logic                  nReset,
  awg_output_coupling_if.slave  bus
);

  localparam int AW = W + K;

  logic signed [AW-1:0] acc_q, acc_d;
  logic                 coupling_q, coupling_d;
  logic signed [W:0]    x_q, x_d;
  logic                 valid1_q;
  logic signed [W-1:0]  out_q, out_d;
  logic                 out_valid_q;

  logic signed [W-1:0]  dc;
  logic signed [W:0]    comp;
  logic                 comp_stb;
  logic signed [W:0]    a_applied;
  logic                 settling;
  logic signed [W+1:0]  s_wide;

  always_comb begin
    // acc/2^K always fits in W bits because acc tracks 2^K times a W-bit mean.
    dc       = W'(acc_q >>> K);
    comp_stb = bus.Input_Valid && (bus.Coupling != coupling_q);
    // DC->AC: X loses DC, so A gains it; AC->DC is the mirror image.
    comp     = bus.Coupling ? (W+1)'(dc) : -((W+1)'(dc));

    acc_d      = acc_q;
    coupling_d = coupling_q;
    x_d        = x_q;
    if (bus.Input_Valid) begin
      acc_d      = acc_q + AW'(bus.Input) - (acc_q >>> K);
      coupling_d = bus.Coupling;
      // Uses the coupling being loaded this cycle, so X and the compensated
      // A are captured together and their sum stays continuous.
      x_d = bus.Coupling ? ((W+1)'(bus.Input) - (W+1)'(dc)) : (W+1)'(bus.Input);
    end

    s_wide = (W+2)'(x_q) + (W+2)'(a_applied);
    out_d  = valid1_q ? W'(sat_to_width(64'(s_wide), W)) : out_q;
  end

  awg_output_coupling_offset_slew #(
    .W    (W),
    .STEP (STEP)
  ) u_offset_slew (
    .Clk      (Clk),
    .nReset   (nReset),
    .target   (bus.Offset),
    .comp     (comp),
    .comp_stb (comp_stb),
    .advance  (bus.Input_Valid),
    .a        (a_applied),
    .settling (settling)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      acc_q       <= '0;
      coupling_q  <= 1'b0;
      x_q         <= '0;
      valid1_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      coupling_q  <= coupling_d;
      x_q         <= x_d;
      valid1_q    <= bus.Input_Valid;
      out_q       <= out_d;
      out_valid_q <= valid1_q;
    end
  end

  assign bus.Output       = out_q;
  assign bus.Output_Valid = out_valid_q;
  assign bus.Settling     = settling;

endmodule
